// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with registered one-hot and index grant.
// A grant is held until its owner drops req; every release is followed by one idle
// cycle before the next grant. Optional forced release after MAX_HOLD cycles is
// compiled in with the RR_ARB_TIMEOUT_EN macro.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e     state_q;
  logic [2:0] ptr_q;

  logic       pick_found;
  logic [2:0] pick_id;
  logic [2:0] search_idx;
  logic       owner_req;
  logic       hold_expired;

  // Reject out-of-range hold limits at elaboration time.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be in 1..255");
  end

  // Search req starting at ptr and wrapping; first hit wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = ptr_q;
    search_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      search_idx = ptr_q + 3'(k);
      if (!pick_found && req[search_idx]) begin
        pick_found = 1'b1;
        pick_id    = search_idx;
      end
    end
  end

  assign owner_req = req[gnt_id];

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_q;

  // Counter reads MAX_HOLD-1 during the last allowed grant cycle.
  assign hold_expired = (hold_q >= 8'(MAX_HOLD - 1));

  // Grant FSM with hold counter and registered timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 3'd0;
      gnt       <= 8'h00;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_q    <= 8'd0;
    end else begin
      timeout <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            gnt_id    <= pick_id;
            gnt       <= 8'h01 << pick_id;
            gnt_valid <= 1'b1;
            hold_q    <= 8'd0;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          // Normal release wins over timeout on the same edge.
          if (!owner_req || hold_expired) begin
            gnt       <= 8'h00;
            gnt_valid <= 1'b0;
            ptr_q     <= gnt_id + 3'd1;
            state_q   <= StIdle;
            timeout   <= owner_req;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;

  // Grant FSM: grant from IDLE, hold until the owner drops req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 3'd0;
      gnt       <= 8'h00;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            gnt_id    <= pick_id;
            gnt       <= 8'h01 << pick_id;
            gnt_valid <= 1'b1;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          if (!owner_req || hold_expired) begin
            gnt       <= 8'h00;
            gnt_valid <= 1'b0;
            ptr_q     <= gnt_id + 3'd1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`endif

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-way round-robin arbiter that shares one resource between eight requesters and emits its grant both as a 3-bit index and as a one-hot vector (3-to-8 decode of the index). It sits in front of any shared datapath selected through a 3x8 decoder. It turns raw request lines into a fair, registered, single-owner select. A grant is held until the owner drops its request. An optional compiled-in timeout forces release.

## Interface
Parameters:
- MAX_HOLD, 16, maximum grant length in cycles when the timeout feature is compiled in; legal range 1..255; ignored otherwise.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst_n  input  1  reset; asynchronous and active-low (already decided).
- req  input  8  request lines; bit i high means requester i wants the resource; level-sensitive.
- gnt  output  8  one-hot grant, always equal to the decode of gnt_id when gnt_valid=1; all zeros otherwise.
- gnt_id  output  3  index of the current owner; holds the last owner when idle.
- gnt_valid  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released; constant 0 when the feature is compiled out.

## Operation
- State machine with two states: IDLE and BUSY. A 3-bit round-robin pointer ptr names the first index to search.
- IDLE:
  - If req==0, stay in IDLE with no output change.
  - Otherwise pick the first i with req[i]=1, searching ptr, ptr+1, … ptr+7 (mod 8).
  - Register gnt_id=i, gnt=1<<i, gnt_valid=1, and go to BUSY.
- BUSY:
  - Hold gnt, gnt_id and gnt_valid while req[gnt_id]=1. Other req bits are ignored, so there is no preemption.
  - Release condition: req[gnt_id] sampled 0, or a forced timeout.
  - On release: gnt=0, gnt_valid=0, ptr=gnt_id+1 (mod 8, so 7 wraps to 0), go to IDLE. gnt_id keeps its value.
- Request bits other than the owner's may toggle freely. Only the values sampled in IDLE matter.
- A release is always followed by one IDLE cycle before the next grant. This is deliberate: it guarantees a dead cycle between owners.
- gnt is never multi-hot. gnt is nonzero if and only if gnt_valid=1.

## Timing
- Reset values: state=IDLE, ptr=0, gnt=8'h00, gnt_id=3'd0, gnt_valid=0, timeout=0, hold counter=0.
- Reset is asynchronous. Asserting rst_n low mid-grant clears all outputs immediately, without waiting for clk.
- Grant latency: request sampled at edge k in IDLE → gnt valid after edge k.
- Release latency: owner's req sampled low at edge k → gnt=0 after edge k.
- Earliest next grant is after edge k+1. Minimum gap between grants is 1 cycle.
- Minimum grant length is 1 cycle: if the owner drops req right after the grant edge, the grant lasts exactly one cycle.
- Simultaneous requests in IDLE are resolved purely by ptr order; there is no fixed priority.

## Configuration
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on every grant and increments each BUSY cycle.
  - When the grant has been active MAX_HOLD cycles and req[gnt_id] is still 1, the next edge releases it (same pointer update as a normal release) and pulses timeout=1 for exactly that one cycle.
  - A normal release on the same edge takes precedence, and timeout stays 0.
- Undefined: no counter is built, timeout is tied 0, and a grant is held indefinitely.

## Test plan
- Reset: drive rst_n=0 with req=8'hFF, then release reset with req=0. gnt=00, gnt_id=0, gnt_valid=0 and timeout=0 throughout, with no grant while req=0.
- Single requester: set req=8'h08 before edge 1. After edge 1, gnt=8'h08, gnt_id=3, gnt_valid=1. Clear req; after the next edge gnt=0 and gnt_valid=0.
- Full rotation: hold req=8'hFF and, each time a grant appears, drop that bit for one cycle before re-raising it. Grant order is 0,1,2,…,7,0, and every handover shows one idle cycle.
- Pointer wrap: after a grant to 4 is released (ptr=5), set req=8'h21. Grant goes to 5 first; after its release it goes to 0.
- Timeout (RR_ARB_TIMEOUT_EN, MAX_HOLD=4): hold req=8'h04. gnt=8'h04 for 4 cycles, then release with a 1-cycle timeout=1, then an idle cycle, then gnt=8'h04 again (the wrap search from ptr=3 reaches 2).
- Async reset mid-grant: while gnt=8'h40, pulse rst_n low between edges. gnt, gnt_valid and gnt_id clear immediately; after reset, req=8'h40 is granted again with ptr starting at 0.
